// File: rtl/si_channel_arbiter.sv
// Packet-aware round-robin arbiter: merges NUM_CHANNELS AXI-Stream tag
// streams into one, switching sources only on tlast boundaries.
`timescale 1ns/1ps
module si_channel_arbiter #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH   = 32,
    parameter int MAX_PACKETS  = 4,
    parameter int ID_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                               usr_clk,
    input  logic                               usr_rst_n,
    input  logic [NUM_CHANNELS-1:0]            s_axis_tvalid,
    output logic [NUM_CHANNELS-1:0]            s_axis_tready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_CHANNELS-1:0]            s_axis_tlast,
    input  logic [NUM_CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
    output logic                               m_axis_tlast,
    output logic [USER_WIDTH-1:0]              m_axis_tuser,
    output logic [ID_WIDTH-1:0]                m_axis_tid,
    input  logic [NUM_CHANNELS-1:0]            channel_enable,
    output logic [31:0]                        packet_count,
    output logic                               busy
);

    typedef enum logic {ST_ARB, ST_PASS} state_t;

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic [7:0]            r_pkt_cnt;
    logic [31:0]           r_packet_count;

    logic [DATA_WIDTH-1:0] w_data [NUM_CHANNELS];
    logic [KEEP_WIDTH-1:0] w_keep [NUM_CHANNELS];
    logic [USER_WIDTH-1:0] w_user [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_cand;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_next;
    int                    w_idx;
    logic                  w_pass;
    logic                  w_xfer;
    logic                  w_eop;

    // Per-channel slices of the flattened input buses, plus request candidates
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign w_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_keep[g] = s_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
        assign w_user[g] = s_axis_tuser[g*USER_WIDTH +: USER_WIDTH];
        assign w_cand[g] = s_axis_tvalid[g] & channel_enable[g];
    end

    // Round-robin pick: first candidate after the last grant, with wrap
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_CHANNELS;
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_next  = ID_WIDTH'(w_idx);
            end
        end
    end

    assign w_pass = (r_state == ST_PASS);
    assign w_xfer = w_pass & s_axis_tvalid[r_grant] & m_axis_tready;
    assign w_eop  = w_xfer & s_axis_tlast[r_grant];

    // Zero-latency mux of the granted channel; valid never looks at tready
    assign m_axis_tvalid = w_pass & s_axis_tvalid[r_grant];
    assign m_axis_tdata  = w_data[r_grant];
    assign m_axis_tkeep  = w_keep[r_grant];
    assign m_axis_tlast  = s_axis_tlast[r_grant];
    assign m_axis_tuser  = w_user[r_grant];
    assign m_axis_tid    = r_grant;
    assign packet_count  = r_packet_count;
    assign busy          = w_pass;

    // Only the granted channel sees downstream ready, and only in PASS
    always_comb begin
        s_axis_tready = '0;
        if (w_pass) s_axis_tready[r_grant] = m_axis_tready;
    end

    // ARB/PASS state machine; rotation only happens at a packet boundary
    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            r_state        <= ST_ARB;
            r_grant        <= '0;
            r_last_grant   <= ID_WIDTH'(NUM_CHANNELS - 1);
            r_pkt_cnt      <= '0;
            r_packet_count <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_found) begin
                        r_grant   <= w_next;
                        r_pkt_cnt <= '0;
                        r_state   <= ST_PASS;
                    end
                end
                default: begin
                    if (w_eop) begin
                        r_packet_count <= r_packet_count + 32'd1;
                        r_pkt_cnt      <= r_pkt_cnt + 8'd1;
                        if ((r_pkt_cnt + 8'd1 == 8'(MAX_PACKETS)) || !channel_enable[r_grant]) begin
                            r_last_grant <= r_grant;
                            r_state      <= ST_ARB;
                        end
                    end
                end
            endcase
        end
    end

endmodule
